// File: rtl/key_entry.sv
// key_entry: debounces scanner key presses, assembles two decimal operands and
// an operator, and issues {a, op, b} to the ALU over a valid/ready handshake.
// Optional build macro: KEY_ENTRY_CLEAR_EN -- '=' on an empty entry clears all.
module key_entry #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned W        = 14,
   parameter int unsigned DEBOUNCE = 2
) (
   input  logic         IN_clk,
   input  logic         IN_reset,
   input  logic [3:0]   IN_value,
   input  logic         IN_key,
   input  logic         IN_ready,
   output logic         OUT_valid,
   output logic [W-1:0] OUT_a,
   output logic [W-1:0] OUT_b,
   output logic [2:0]   OUT_op,
   output logic [W-1:0] OUT_disp,
   output logic [1:0]   OUT_state
);

   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam int unsigned DW = $clog2(DIGITS + 1);
   localparam int unsigned PW = W + 4;

   typedef enum logic [1:0] {
      ST_A     = 2'd0,
      ST_B     = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [DW-1:0]  dig_q, dig_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           armed_q, armed_d;
   logic           valid_q, valid_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [2:0]     op_q, op_d;
   logic           accept;
   logic           is_digit;
   logic           is_oper;
   logic           is_eq;

   assign is_digit = (IN_value < 4'd10);
   assign is_oper  = (IN_value >= 4'd10) && (IN_value <= 4'd14);
   assign is_eq    = (IN_value == 4'd15);

   // Press detector: saturating high-sample counter, one accept per press
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      accept  = 1'b0;
      if (!IN_key) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end else begin
         if (cnt_q != CW'(DEBOUNCE)) begin
            cnt_d = cnt_q + CW'(1);
         end
         if (armed_q && (cnt_q == CW'(DEBOUNCE - 1))) begin
            accept  = 1'b1;
            armed_d = 1'b0;
         end
      end
   end

   // Entry FSM: operand assembly, operator capture and issue handshake
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      dig_d   = dig_q;
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      case (state_q)
         ST_A, ST_B: begin
            if (accept) begin
               if (is_digit) begin
                  if (dig_q < DW'(DIGITS)) begin
                     acc_d = W'(({4'b0000, acc_q} * PW'(10)) + PW'(IN_value));
                     dig_d = dig_q + DW'(1);
                  end
               end else if (is_oper) begin
                  if (state_q == ST_A) begin
                     a_d     = acc_q;
                     op_d    = 3'(IN_value - 4'd10);
                     acc_d   = '0;
                     dig_d   = '0;
                     state_d = ST_B;
                  end else if (dig_q == '0) begin
                     op_d = 3'(IN_value - 4'd10);
                  end
               end else if (is_eq) begin
`ifdef KEY_ENTRY_CLEAR_EN
                  if ((state_q == ST_A) || (dig_q == '0)) begin
                     acc_d   = '0;
                     dig_d   = '0;
                     a_d     = '0;
                     b_d     = '0;
                     op_d    = '0;
                     state_d = ST_A;
                  end else begin
                     b_d     = acc_q;
                     valid_d = 1'b1;
                     state_d = ST_ISSUE;
                  end
`else
                  if (state_q == ST_B) begin
                     b_d     = acc_q;
                     valid_d = 1'b1;
                     state_d = ST_ISSUE;
                  end
`endif
               end
            end
         end
         ST_ISSUE: begin
            // accepted presses are dropped here; only the handshake matters
            if (valid_q && IN_ready) begin
               valid_d = 1'b0;
               acc_d   = '0;
               dig_d   = '0;
               state_d = ST_A;
            end
         end
         default: begin
            acc_d   = '0;
            dig_d   = '0;
            state_d = ST_A;
         end
      endcase
   end

   // State register with synchronous reset taking priority over all events
   always_ff @(posedge IN_clk) begin
      if (IN_reset) begin
         state_q <= ST_A;
         acc_q   <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b1;
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   assign OUT_valid = valid_q;
   assign OUT_a     = a_q;
   assign OUT_b     = b_q;
   assign OUT_op    = op_q;
   assign OUT_state = state_q;
   assign OUT_disp  = (state_q == ST_ISSUE) ? b_q : acc_q;

endmodule
